// File: rtl/sm_mdu.sv
// sm_mdu -- iterative multiply/divide unit for the schoolMIPS datapath.
// Executes MULTU/MULT (shift-add) and DIVU/DIV (restoring division) one bit
// per cycle and writes a HI:LO result pair.
// Build option: define SM_MDU_DIV_EN to include the divider. Without it the
// divide ops complete immediately with hi = lo = 0 and divZero tied low.
//
// Handshake: the unit accepts `start` only while idle (busy = 0). Accepting
// a start raises `busy` on the next cycle. `busy` stays high until the result
// is written. `done` then pulses for one cycle with busy = 0 and new hi/lo.
// A start in the done cycle is accepted. A start while busy is dropped, and
// flush forces the unit back to idle without writing results.
module sm_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             divZero,
   output logic [1:0]       dbgState
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } stateT;

   stateT              state;
   logic               isDiv;     // latched op[1]
   logic [CW-1:0]      cnt;       // iterations remaining
   logic [WIDTH-1:0]   mcand;     // multiplicand magnitude, or divisor magnitude
   logic [2*WIDTH-1:0] prod;      // multiply: {partial, multiplier}; divide: {rem, quo}
   logic               negQ;      // product sign, or quotient sign

   logic [WIDTH-1:0]   absA;
   logic [WIDTH-1:0]   absB;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] prodFix;

`ifdef SM_MDU_DIV_EN
   logic               negR;      // remainder sign
   logic               bZero;     // divisor was zero
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divDiff;
   logic [WIDTH-1:0]   quoFix;
   logic [WIDTH-1:0]   remFix;
`endif

   assign dbgState = state;

`ifndef SM_MDU_DIV_EN
   assign divZero = 1'b0;
`endif

   // Operand magnitudes, one shift-add / restoring step, and the final sign fix.
   always_comb begin
      absA    = (op[0] && srcA[WIDTH-1]) ? -srcA : srcA;
      absB    = (op[0] && srcB[WIDTH-1]) ? -srcB : srcB;
      mulSum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prodFix = negQ ? -prod : prod;
`ifdef SM_MDU_DIV_EN
      // Bring the next dividend bit into the partial remainder and trial-subtract.
      // The partial remainder stays below the divisor, so bit WIDTH of the
      // difference is a clean borrow flag.
      divShift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      divDiff  = divShift - {1'b0, mcand};
      quoFix   = negQ ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      remFix   = negR ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
`endif
   end

   // Control FSM, iteration datapath and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
         isDiv <= 1'b0;
         mcand <= '0;
         prod  <= '0;
         negQ  <= 1'b0;
`ifdef SM_MDU_DIV_EN
         negR    <= 1'b0;
         bZero   <= 1'b0;
         divZero <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     isDiv <= op[1];
                     busy  <= 1'b1;
                     cnt   <= CW'(WIDTH);
                     negQ  <= op[0] & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
`ifdef SM_MDU_DIV_EN
                     negR  <= op[0] & srcA[WIDTH-1];
                     bZero <= (srcB == '0);
                     if (op[1]) begin
                        mcand <= absB;
                        prod  <= {{WIDTH{1'b0}}, absA};
                     end else begin
                        mcand <= absA;
                        prod  <= {{WIDTH{1'b0}}, absB};
                     end
                     state <= RUN;
`else
                     mcand <= absA;
                     prod  <= {{WIDTH{1'b0}}, absB};
                     state <= op[1] ? FIX : RUN;
`endif
                  end
               end

               RUN: begin
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     state <= FIX;
                  end
`ifdef SM_MDU_DIV_EN
                  if (isDiv) begin
                     if (!divDiff[WIDTH]) begin
                        prod <= {divDiff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
                     end else begin
                        prod <= {divShift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     prod <= {mulSum, prod[WIDTH-1:1]};
                  end
`else
                  prod <= {mulSum, prod[WIDTH-1:1]};
`endif
               end

               FIX: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef SM_MDU_DIV_EN
                  if (isDiv) begin
                     divZero <= bZero;
                     // With a zero divisor the partial remainder ends up holding
                     // |srcA|, so the remainder sign fix restores srcA exactly.
                     lo      <= bZero ? '1 : quoFix;
                     hi      <= remFix;
                  end else begin
                     divZero  <= 1'b0;
                     {hi, lo} <= prodFix;
                  end
`else
                  if (isDiv) begin
                     {hi, lo} <= '0;
                  end else begin
                     {hi, lo} <= prodFix;
                  end
`endif
               end

               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sm_mdu.sv
// tb_sm_mdu -- directed bench for sm_mdu (WIDTH = 32). Expected results are
// queued when an operation is issued; a monitor pops and compares on done.
module tb_sm_mdu;

   localparam int W = 32;
`ifdef SM_MDU_DIV_EN
   localparam bit DIVEN = 1'b1;
`else
   localparam bit DIVEN = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           cyc;
   } expT;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vecT;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] srcA;
   logic [W-1:0] srcB;
   logic         flush;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         divZero;
   logic [1:0]   dbgState;

   expT          expQ[$];
   expT          monE;
   vecT          vecs[11];
   int           cycCnt;
   int           total;
   int           bad;
   logic [W-1:0] lastHi;
   logic [W-1:0] lastLo;

   sm_mdu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .srcA     (srcA),
      .srcB     (srcB),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .divZero  (divZero),
      .dbgState (dbgState)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycCnt = 0;
   always @(posedge clk) cycCnt <= cycCnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cycCnt, act, exp);
      end
   endtask

   function automatic int lat(input logic [1:0] o);
      return (o[1] && !DIVEN) ? 2 : W + 2;
   endfunction

   // Drive a one-cycle start; called at a negedge, returns one cycle later.
   task automatic pulseStart(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             output int c);
      c     = cycCnt;
      op    = o;
      srcA  = a;
      srcB  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op    = 2'($urandom_range(0, 3));
      srcA  = $urandom;
      srcB  = $urandom;
   endtask

   // Issue an operation and queue its expected result.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                        output int c);
      expT e;
      if (o[1] && !DIVEN) begin
         eh = '0;
         el = '0;
         ez = 1'b0;
      end
      e.hi   = eh;
      e.lo   = el;
      e.dz   = ez;
      e.cyc  = cycCnt + lat(o);
      lastHi = eh;
      lastLo = el;
      expQ.push_back(e);
      pulseStart(o, a, b, c);
   endtask

   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (expQ.size() != 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: %0d results still pending after %0d cycles", expQ.size(), n);
         expQ.delete();
      end
   endtask

   // Monitor: compare every done pulse against the head of the queue.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done at cycle %0d: got hi=%h lo=%h, expected no done", cycCnt, hi, lo);
         end else begin
            monE = expQ.pop_front();
            check("hi", hi, monE.hi);
            check("lo", lo, monE.lo);
            check("divZero", W'(divZero), W'(monE.dz));
            check("done_cycle", W'(cycCnt), W'(monE.cyc));
            check("busy_at_done", W'(busy), '0);
            check("state_at_done", W'(dbgState), '0);
         end
      end
   end

   // Stimulus
   initial begin
      int c;
      int c2;
      int dcyc;
      int errs;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'b00;
      srcA  = '0;
      srcB  = '0;

      vecs[0]  = '{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
      vecs[1]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[2]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
      vecs[3]  = '{2'b01, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
      vecs[4]  = '{2'b00, 32'd0,        32'h00012345, 32'h00000000, 32'h00000000, 1'b0};
      vecs[5]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[7]  = '{2'b10, 32'd100,      32'd3,        32'd1,        32'd33,       1'b0};
      vecs[8]  = '{2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
      vecs[9]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
      vecs[10] = '{2'b11, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};

      repeat (3) @(negedge clk);
      check("reset_busy", W'(busy), '0);
      check("reset_done", W'(done), '0);
      check("reset_hi", hi, '0);
      check("reset_lo", lo, '0);
      check("reset_divZero", W'(divZero), '0);
      check("reset_state", W'(dbgState), '0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // MULTU max x max with the busy window traced cycle by cycle
      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, c);
      errs = 0;
      for (int k = 0; k < W + 2; k++) begin
         if (busy !== (cycCnt <= c + W + 1)) errs++;
         @(negedge clk);
      end
      check("busy_profile_errors", W'(errs), '0);
      waitDrain();

      // Directed vectors
      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, c);
         waitDrain();
      end

      // DIVU by zero, then MULTU launched in its done cycle
      issue(2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, c);
      dcyc = c + lat(2'b10);
      while (cycCnt < dcyc) @(negedge clk);
      issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, c2);
      waitDrain();

      // Start re-pulsed mid-run is ignored
      issue(2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, c);
      while (cycCnt < c + 5) @(negedge clk);
      pulseStart(2'b01, 32'd3, 32'd3, c2);
      waitDrain();
      repeat (40) @(negedge clk);

      // Flush mid-run: no done, results unchanged
      pulseStart(2'b00, 32'd3, 32'd4, c);
      while (cycCnt < c + 10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", W'(busy), '0);
      repeat (40) @(negedge clk);
      check("flush_hi_kept", hi, lastHi);
      check("flush_lo_kept", lo, lastLo);

      // Flush beats start in idle
      flush = 1'b1;
      pulseStart(2'b00, 32'd9, 32'd9, c);
      flush = 1'b0;
      check("flush_start_busy", W'(busy), '0);
      repeat (40) @(negedge clk);

      // Asynchronous reset mid-run
      pulseStart(2'b00, 32'd5, 32'd5, c);
      while (cycCnt < c + 10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", W'(busy), '0);
      check("async_rst_hi", hi, '0);
      check("async_rst_lo", lo, '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("post_rst_hi", hi, '0);
      check("post_rst_state", W'(dbgState), '0);

      check("queue_left", W'(expQ.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sm_mdu.md
# sm_mdu

Parametrised iterative multiply/divide unit for the schoolMIPS datapath. It replaces the single-cycle combinational MUL in the ALU with a multi-cycle MULT/MULTU/DIV/DIVU engine that produces a HI:LO result pair. It sits beside the ALU, is launched by the control unit with a one-cycle `start` pulse, and stalls the core via `busy` until `done`.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be even and ≥ 4. HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation: 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV.
- `srcA`  in  WIDTH  multiplicand / dividend.
- `srcB`  in  WIDTH  multiplier / divisor.
- `flush`  in  1  abort the operation in progress.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse: `hi`/`lo` were just updated.
- `hi`  out  WIDTH  multiply: upper product half. Divide: remainder.
- `lo`  out  WIDTH  multiply: lower product half. Divide: quotient.
- `divZero`  out  1  registered; high together with `done` when the divisor was 0.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE → RUN on `start`.
  - RUN → FIX when the iteration counter reaches 0.
  - FIX → IDLE unconditionally.
- Start (IDLE, `start`=1):
  - Latch `op`.
  - Signed ops: latch |srcA| and |srcB|, and record the result signs:
    - product sign = sign(A) XOR sign(B);
    - quotient sign = sign(A) XOR sign(B);
    - remainder sign = sign(A).
  - Unsigned ops: latch the operands raw.
  - Load counter = WIDTH.
- RUN: one bit per cycle, WIDTH cycles total; the counter decrements each cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
- FIX:
  - Negate the 2·WIDTH product if the product sign is set.
  - Negate the quotient and the remainder independently per their signs.
  - Write `hi`/`lo`, pulse `done`, load `divZero`.
- All arithmetic is unsigned on magnitudes; negation is two's complement at full width.
  - |MIN| is represented as 2^(WIDTH-1) unsigned.
  - As a result, DIV MIN/−1 yields lo = MIN, hi = 0.
- Divide by zero (divisor = 0), any divide op:
  - lo = all ones, hi = srcA raw;
  - sign fix is skipped; `divZero` = 1.
- `divZero` is 0 for every multiply and for every non-zero-divisor divide.
- `hi`, `lo` and `divZero` hold their values until the next FIX; an abort leaves them unchanged.
- `start` while busy is ignored; no queuing.
- `flush`=1 in RUN or FIX: next state is IDLE, no `done`, `hi`/`lo`/`divZero` unchanged.
- `flush` in IDLE has priority over `start`: the start is dropped.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `divZero`=0, `hi`=0, `lo`=0, counter 0.
- Reset takes effect immediately and asynchronously, including mid-operation.
- `start` asserted in cycle c:
  - `busy`=1 in cycles c+1 … c+WIDTH+1;
  - `done`=1 and the new `hi`/`lo` are visible in cycle c+WIDTH+2 (cycle 34 for WIDTH=32).
- `done` is high for exactly one cycle. `busy`=0 in that cycle, and the FSM is in IDLE.
- A `start` in the `done` cycle is accepted: back-to-back operations run every WIDTH+2 cycles.
- `busy` and `done` are registered outputs; there is no combinational path from `start`.
- The operands and `op` are needed only in the `start` cycle and may change afterwards.

## Configuration
- `SM_MDU_DIV_EN` defined: full unit as described above.
- `SM_MDU_DIV_EN` undefined:
  - divider datapath, remainder/quotient sign logic and `divZero` logic are removed;
  - `divZero` is tied to 0;
  - DIVU/DIV go IDLE → FIX directly: `busy` in c+1, `done` in c+2, `hi`=`lo`=0;
  - multiply behaviour and timing are identical to the full unit.

## Test plan
All scenarios use WIDTH=32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start in cycle 0 → hi=0xFFFFFFFE, lo=0x00000001; `done` only in cycle 34; `busy` in cycles 1–33.
- MULT −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100 / 3 → lo=33, hi=1, divZero=0.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=100, divZero=1.
- Full-unit build: one DIVU performed with divZero=1, then MULTU 6 × 7 launched in the DIVU's `done` cycle → divZero=0 alongside hi=0, lo=42 at that `done`; `done` 34 cycles after the DIVU's `done`.
- `start` re-pulsed in cycle 5 of a run → ignored, single `done` at cycle 34.
- `flush` in cycle 10 → no `done`, `hi`/`lo` keep their prior values.
- `rst_n` low in cycle 10 → `busy`=`hi`=`lo`=0 immediately.
- Build without `SM_MDU_DIV_EN`: DIVU 100/3 → `done` in cycle 2, hi=lo=0, divZero=0; MULTU results and timing match the full build.
